// File: rtl/pipelined_slice_adder_if.sv
// Valid/ready operand and result bus for pipelined_slice_adder.
// The master side supplies operands and accepts results; the adder is the slave.
interface pipelined_slice_adder_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] A;
  logic [B_WIDTH-1:0] B;
  logic               out_valid;
  logic               out_ready;
  logic [A_WIDTH-1:0] S;
  logic               carry;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, S, carry
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, S, carry
  );
endinterface

// File: rtl/pipelined_slice_adder.sv
// Pipelined unsigned A + zero_ext(B) adder, carry chain cut into SLICE_WIDTH-bit registered slices.
// Optional macro ADDER_SATURATE_EN clamps S to all ones on overflow (carry still reports it).
module pipelined_slice_adder #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 4,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  pipelined_slice_adder_if.slave   bus
);
  localparam int NUM_SLICES = A_WIDTH / SLICE_WIDTH;

  if ((A_WIDTH % SLICE_WIDTH) != 0 || B_WIDTH < 1 || B_WIDTH > A_WIDTH) begin : g_bad_params
    $error("pipelined_slice_adder: illegal A_WIDTH/B_WIDTH/SLICE_WIDTH combination");
  end

`ifdef ADDER_SATURATE_EN
  function automatic logic [A_WIDTH-1:0] sat_sum(input logic [A_WIDTH-1:0] s, input logic ovf);
    return ovf ? {A_WIDTH{1'b1}} : s;
  endfunction
`endif

  logic [A_WIDTH-1:0] b_ext;
  logic               stall;

  always_comb begin
    b_ext              = '0;
    b_ext[B_WIDTH-1:0] = bus.B;
  end

  // A full output that is not being taken freezes the whole pipe.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = rst || !stall;

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_stg
    localparam int LO = k * SLICE_WIDTH;

    logic [A_WIDTH-1:0]   a_src, b_src, s_src, s_nxt;
    logic                 c_src, vld_src;
    logic [SLICE_WIDTH:0] slice_sum;
    logic [A_WIDTH-1:0]   s_p;
    logic                 c_p, vld_p;
    logic                 unused_src_bits;

    if (k == 0) begin : g_src
      assign a_src   = bus.A;
      assign b_src   = b_ext;
      assign s_src   = '0;
      assign c_src   = 1'b0;
      assign vld_src = bus.in_valid;
    end else begin : g_src
      assign a_src   = g_stg[k-1].g_mid.a_p;
      assign b_src   = g_stg[k-1].g_mid.b_p;
      assign s_src   = g_stg[k-1].s_p;
      assign c_src   = g_stg[k-1].c_p;
      assign vld_src = g_stg[k-1].vld_p;
    end

    // Operand bits already consumed by earlier slices are carried but no longer read.
    assign unused_src_bits = ^{a_src, b_src};

    assign slice_sum = {1'b0, a_src[LO +: SLICE_WIDTH]}
                     + {1'b0, b_src[LO +: SLICE_WIDTH]}
                     + {{SLICE_WIDTH{1'b0}}, c_src};

    always_comb begin
      s_nxt                     = s_src;
      s_nxt[LO +: SLICE_WIDTH]  = slice_sum[SLICE_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= 1'b0;
      end else if (!stall) begin
        vld_p <= vld_src;
      end
    end

    if (k < NUM_SLICES - 1) begin : g_mid
      logic [A_WIDTH-1:0] a_p, b_p;

      // ---- stage k -> k+1 boundary: skew/deskew data registers ----
      always_ff @(posedge clk) begin
        if (!stall) begin
          a_p <= a_src;
          b_p <= b_src;
          s_p <= s_nxt;
          c_p <= slice_sum[SLICE_WIDTH];
        end
      end
    end else begin : g_last
      // ---- final stage: output register, reset to zero ----
      always_ff @(posedge clk) begin
        if (rst) begin
          s_p <= '0;
          c_p <= 1'b0;
        end else if (!stall) begin
`ifdef ADDER_SATURATE_EN
          s_p <= sat_sum(s_nxt, slice_sum[SLICE_WIDTH]);
`else
          s_p <= s_nxt;
`endif
          c_p <= slice_sum[SLICE_WIDTH];
        end
      end
    end
  end

  assign bus.out_valid = g_stg[NUM_SLICES-1].vld_p;
  assign bus.S         = g_stg[NUM_SLICES-1].s_p;
  assign bus.carry     = g_stg[NUM_SLICES-1].c_p;
endmodule

// File: tb/tb_pipelined_slice_adder.sv
// Scoreboard bench for pipelined_slice_adder: default 8/4/4 instance plus a 16/8/4 instance.
module tb_pipelined_slice_adder;
  localparam int AW  = 8;
  localparam int BW  = 4;
  localparam int AW2 = 16;
  localparam int BW2 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_slice_adder_if #(.A_WIDTH(AW),  .B_WIDTH(BW))  bus  ();
  pipelined_slice_adder_if #(.A_WIDTH(AW2), .B_WIDTH(BW2)) bus2 ();

  pipelined_slice_adder #(.A_WIDTH(AW), .B_WIDTH(BW), .SLICE_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pipelined_slice_adder #(.A_WIDTH(AW2), .B_WIDTH(BW2), .SLICE_WIDTH(4)) dut_wide (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [AW:0] sbq[$];

  // Reference: exact sum, optionally clamped when the build saturates.
  function automatic logic [AW:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [AW:0] r;
    r = {1'b0, a} + {{(AW+1-BW){1'b0}}, b};
`ifdef ADDER_SATURATE_EN
    if (r[AW]) r[AW-1:0] = '1;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.A = '0; bus2.B = '0; bus2.out_ready = 1'b1;
    step(); step();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during actual=%b required=1", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.carry, bus.S} !== 10'h000)
      begin errors++; $display("FAIL reset_outputs actual=%b/%b/%h required=0/0/00", bus.out_valid, bus.carry, bus.S); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after actual=%b required=1", bus.in_ready); end
    // Two operations in flight with the output stalled, then reset.
    bus.in_valid = 1'b1; bus.A = 8'h11; bus.B = 4'h1;
    step();
    bus.A = 8'h22; bus.B = 4'h2;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL reset_prefill actual=%b required=1", bus.out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_stalled actual=%b required=1", bus.in_ready); end
    step();
    checks++;
    if ({bus.out_valid, bus.carry, bus.S, bus.in_ready} !== {10'h000, 1'b1})
      begin errors++; $display("FAIL reset_midstream actual=%b/%b/%h/%b required=0/0/00/1", bus.out_valid, bus.carry, bus.S, bus.in_ready); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard cycle=%0d actual=%b required=0", i, bus.out_valid); end
      step();
    end
  endtask

  task automatic test_basic();
    logic [AW:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.A = 8'h37; bus.B = 4'h5;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready actual=%b required=1", bus.in_ready); end
    sbq.push_back(model(bus.A, bus.B));
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early actual=%b required=0", bus.out_valid); end
    step();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency actual=%b required=1", bus.out_valid); end
    exp = sbq.pop_front();
    checks++;
    if ({bus.carry, bus.S} !== exp) begin errors++; $display("FAIL basic_model actual=%h required=%h", {bus.carry, bus.S}, exp); end
    checks++;
    if ({bus.carry, bus.S} !== 9'h03C) begin errors++; $display("FAIL basic_const actual=%h required=03c", {bus.carry, bus.S}); end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_single actual=%b required=0", bus.out_valid); end
  endtask

  task automatic test_cross_carry();
    logic [AW-1:0] ta[2];
    logic [BW-1:0] tb[2];
    logic [AW:0]   tk[2];
    logic [AW:0]   exp;
    ta[0] = 8'h0F; tb[0] = 4'h1; tk[0] = 9'h010;
    ta[1] = 8'hFF; tb[1] = 4'hF;
`ifdef ADDER_SATURATE_EN
    tk[1] = 9'h1FF;
`else
    tk[1] = 9'h10E;
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.A = ta[i]; bus.B = tb[i];
      sbq.push_back(model(ta[i], tb[i]));
      step();
      bus.in_valid = 1'b0;
      step();
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cross_valid_%0d actual=%b required=1", i, bus.out_valid); end
      exp = sbq.pop_front();
      checks++;
      if ({bus.carry, bus.S} !== exp) begin errors++; $display("FAIL cross_model_%0d actual=%h required=%h", i, {bus.carry, bus.S}, exp); end
      checks++;
      if ({bus.carry, bus.S} !== tk[i]) begin errors++; $display("FAIL cross_const_%0d actual=%h required=%h", i, {bus.carry, bus.S}, tk[i]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    logic [AW:0] exp;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      if (cyc < 16) begin
        bus.in_valid = 1'b1;
        bus.A = 8'($urandom_range(0, 255));
        bus.B = 4'($urandom_range(0, 15));
        sbq.push_back(model(bus.A, bus.B));
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (cyc != got + 1) begin errors++; $display("FAIL b2b_timing result=%0d actual_cycle=%0d required_cycle=%0d", got, cyc, got + 1); end
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL b2b_extra actual=%h required=none", {bus.carry, bus.S});
        end else begin
          exp = sbq.pop_front();
          if ({bus.carry, bus.S} !== exp) begin errors++; $display("FAIL b2b_data result=%0d actual=%h required=%h", got, {bus.carry, bus.S}, exp); end
        end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 16 || sbq.size() != 0) begin errors++; $display("FAIL b2b_count actual=%0d required=16", got); sbq.delete(); end
    step();
  endtask

  task automatic test_back_pressure();
    int sent = 0;
    int got = 0;
    logic [AW:0] held;
    logic [AW:0] exp;
    held = '0;
    for (int cyc = 0; cyc < 60 && (sent < 10 || sbq.size() > 0); cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 10) begin
        bus.in_valid = 1'b1;
        bus.A = 8'(sent * 37 + 11);
        bus.B = 4'(sent + 3);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
          begin errors++; $display("FAIL bp_stall cycle=%0d actual=%b/%b required=0/1", cyc, bus.in_ready, bus.out_valid); end
        if (cyc == 3) held = {bus.carry, bus.S};
        else begin
          checks++;
          if ({bus.carry, bus.S} !== held) begin errors++; $display("FAIL bp_frozen cycle=%0d actual=%h required=%h", cyc, {bus.carry, bus.S}, held); end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back(model(bus.A, bus.B));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL bp_extra actual=%h required=none", {bus.carry, bus.S});
        end else begin
          exp = sbq.pop_front();
          if ({bus.carry, bus.S} !== exp) begin errors++; $display("FAIL bp_data result=%0d actual=%h required=%h", got, {bus.carry, bus.S}, exp); end
        end
        got++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (sent != 10 || got != 10 || sbq.size() != 0)
      begin errors++; $display("FAIL bp_count sent=%0d got=%0d required=10/10", sent, got); sbq.delete(); end
  endtask

  task automatic test_param_sweep();
    logic [AW2:0] req;
`ifdef ADDER_SATURATE_EN
    req = 17'h1FFFF;
`else
    req = 17'h10000;
`endif
    bus2.out_ready = 1'b1;
    bus2.in_valid = 1'b1; bus2.A = 16'hFFF0; bus2.B = 8'h10;
    #1;
    checks++;
    if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready actual=%b required=1", bus2.in_ready); end
    step();
    bus2.in_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      checks++;
      if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL sweep_early edge=t+%0d actual=%b required=0", e, bus2.out_valid); end
      step();
    end
    checks++;
    if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_latency actual=%b required=1", bus2.out_valid); end
    checks++;
    if ({bus2.carry, bus2.S} !== req) begin errors++; $display("FAIL sweep_data actual=%h required=%h", {bus2.carry, bus2.S}, req); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cross_carry();
    test_back_to_back();
    test_back_pressure();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
